cpu_reg_bank: RTL and testbench

Parametrised, clocked register bank for the 6502 datapath. It holds the accumulator (A), index registers (X, Y), stack pointer (S) and ALU input register (AI), and drives the SB, DB and ADL internal buses. S has built-in increment and decrement with wrap detection. SB drive contention is flagged. The bank sits between the control decoder (load/enable strobes) and the ALU/address-bus logic.

---
 rtl/cpu_reg_bank.sv | 98 +++++++++
 tb/tb_cpu_reg_bank.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_reg_bank.sv
// 6502 datapath register bank: A, X, Y, S, AI with SB/DB/ADL bus drivers.
// SB is modelled as a precharged wired-AND bus; overlapping drivers are flagged.
module cpu_reg_bank #(
  parameter int unsigned      WIDTH   = 8,
  parameter logic [WIDTH-1:0] S_RESET = '1
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [WIDTH-1:0] SB_DATA,
  input  logic [WIDTH-1:0] DAA_DATA,
  input  logic             A_LOAD,
  input  logic             X_LOAD,
  input  logic             Y_LOAD,
  input  logic             S_LOAD,
  input  logic             AI_SB_LOAD,
  input  logic             AI_ZERO_LOAD,
  input  logic             S_INC,
  input  logic             S_DEC,
  input  logic             A_SB_EN,
  input  logic             X_SB_EN,
  input  logic             Y_SB_EN,
  input  logic             S_SB_EN,
  input  logic             A_DB_EN,
  input  logic             S_ADL_EN,
  input  logic             ERR_CLR,
  output logic [WIDTH-1:0] SB_OUT,
  output logic [WIDTH-1:0] DB_OUT,
  output logic [WIDTH-1:0] ADL_OUT,
  output logic [WIDTH-1:0] AI_OUT,
  output logic             S_WRAP,
  output logic             BUS_CONFLICT,
  output logic             BUS_ERR
);

  logic [WIDTH-1:0] r_a, r_x, r_y, r_s, r_ai;
  logic             r_wrap, r_err;
  logic [2:0]       w_sb_cnt;
  logic [WIDTH-1:0] w_sb;

  assign w_sb_cnt = 3'(A_SB_EN) + 3'(X_SB_EN) + 3'(Y_SB_EN) + 3'(S_SB_EN);

  always_comb begin
    w_sb = '1;
    if (A_SB_EN) w_sb = w_sb & r_a;
    if (X_SB_EN) w_sb = w_sb & r_x;
    if (Y_SB_EN) w_sb = w_sb & r_y;
    if (S_SB_EN) w_sb = w_sb & r_s;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_a  <= '0;
      r_x  <= '0;
      r_y  <= '0;
      r_ai <= '0;
    end else begin
      if (A_LOAD) r_a <= DAA_DATA;
      if (X_LOAD) r_x <= SB_DATA;
      if (Y_LOAD) r_y <= SB_DATA;
      if (AI_SB_LOAD)        r_ai <= SB_DATA;
      else if (AI_ZERO_LOAD) r_ai <= '0;
    end
  end

  // S_LOAD overrides INC/DEC; simultaneous INC and DEC cancel out.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_s    <= S_RESET;
      r_wrap <= 1'b0;
    end else if (S_LOAD) begin
      r_s    <= SB_DATA;
      r_wrap <= 1'b0;
    end else if (S_INC && !S_DEC) begin
      r_s    <= r_s + WIDTH'(1);
      r_wrap <= (r_s == '1);
    end else if (S_DEC && !S_INC) begin
      r_s    <= r_s - WIDTH'(1);
      r_wrap <= (r_s == '0);
    end else begin
      r_wrap <= 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)            r_err <= 1'b0;
    else if (BUS_CONFLICT) r_err <= 1'b1;
    else if (ERR_CLR)      r_err <= 1'b0;
  end

  assign BUS_CONFLICT = (w_sb_cnt >= 3'd2);
  assign SB_OUT       = w_sb;
  assign DB_OUT       = A_DB_EN  ? r_a : '1;
  assign ADL_OUT      = S_ADL_EN ? r_s : '1;
  assign AI_OUT       = r_ai;
  assign S_WRAP       = r_wrap;
  assign BUS_ERR      = r_err;

endmodule

// File: tb/tb_cpu_reg_bank.sv
// Self-checking bench for cpu_reg_bank: directed scenarios with literal
// expectations, then randomized traffic against an arithmetic reference model.
module tb_cpu_reg_bank;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b1;
  logic [7:0] SB_DATA, DAA_DATA;
  logic       A_LOAD, X_LOAD, Y_LOAD, S_LOAD, AI_SB_LOAD, AI_ZERO_LOAD;
  logic       S_INC, S_DEC, A_SB_EN, X_SB_EN, Y_SB_EN, S_SB_EN;
  logic       A_DB_EN, S_ADL_EN, ERR_CLR;
  logic [7:0] SB_OUT, DB_OUT, ADL_OUT, AI_OUT;
  logic       S_WRAP, BUS_CONFLICT, BUS_ERR;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  // reference state, plain integers 0..255
  int m_a = 0, m_x = 0, m_y = 0, m_s = 255, m_ai = 0;
  int m_wrap = 0, m_err = 0;

  cpu_reg_bank #(.WIDTH(8), .S_RESET(8'hFF)) dut (
    .CLK(CLK), .RST_N(RST_N), .SB_DATA(SB_DATA), .DAA_DATA(DAA_DATA),
    .A_LOAD(A_LOAD), .X_LOAD(X_LOAD), .Y_LOAD(Y_LOAD), .S_LOAD(S_LOAD),
    .AI_SB_LOAD(AI_SB_LOAD), .AI_ZERO_LOAD(AI_ZERO_LOAD),
    .S_INC(S_INC), .S_DEC(S_DEC),
    .A_SB_EN(A_SB_EN), .X_SB_EN(X_SB_EN), .Y_SB_EN(Y_SB_EN), .S_SB_EN(S_SB_EN),
    .A_DB_EN(A_DB_EN), .S_ADL_EN(S_ADL_EN), .ERR_CLR(ERR_CLR),
    .SB_OUT(SB_OUT), .DB_OUT(DB_OUT), .ADL_OUT(ADL_OUT), .AI_OUT(AI_OUT),
    .S_WRAP(S_WRAP), .BUS_CONFLICT(BUS_CONFLICT), .BUS_ERR(BUS_ERR)
  );

  always #5 CLK = ~CLK;

  function automatic int n_sb_en();
    return int'(A_SB_EN) + int'(X_SB_EN) + int'(Y_SB_EN) + int'(S_SB_EN);
  endfunction

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      m_a <= 0; m_x <= 0; m_y <= 0; m_ai <= 0; m_s <= 255;
      m_wrap <= 0; m_err <= 0;
    end else begin
      if (A_LOAD) m_a <= int'(DAA_DATA);
      if (X_LOAD) m_x <= int'(SB_DATA);
      if (Y_LOAD) m_y <= int'(SB_DATA);
      if (AI_SB_LOAD)        m_ai <= int'(SB_DATA);
      else if (AI_ZERO_LOAD) m_ai <= 0;
      if (S_LOAD) begin
        m_s <= int'(SB_DATA); m_wrap <= 0;
      end else if (S_INC && !S_DEC) begin
        m_s <= (m_s + 1) % 256; m_wrap <= (m_s == 255) ? 1 : 0;
      end else if (S_DEC && !S_INC) begin
        m_s <= (m_s + 255) % 256; m_wrap <= (m_s == 0) ? 1 : 0;
      end else begin
        m_wrap <= 0;
      end
      if (n_sb_en() >= 2) m_err <= 1;
      else if (ERR_CLR)   m_err <= 0;
    end
  end

  task automatic cmp(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Per-cycle comparison against the model, sampled mid-cycle.
  always @(negedge CLK) begin
    if (chk_en) begin
      int exp_sb;
      exp_sb = 255;
      if (A_SB_EN) exp_sb = exp_sb & m_a;
      if (X_SB_EN) exp_sb = exp_sb & m_x;
      if (Y_SB_EN) exp_sb = exp_sb & m_y;
      if (S_SB_EN) exp_sb = exp_sb & m_s;
      cmp("model_SB_OUT",  int'(SB_OUT),  exp_sb);
      cmp("model_DB_OUT",  int'(DB_OUT),  A_DB_EN  ? m_a : 255);
      cmp("model_ADL_OUT", int'(ADL_OUT), S_ADL_EN ? m_s : 255);
      cmp("model_AI_OUT",  int'(AI_OUT),  m_ai);
      cmp("model_S_WRAP",  int'(S_WRAP),  m_wrap);
      cmp("model_CONFLICT", int'(BUS_CONFLICT), (n_sb_en() >= 2) ? 1 : 0);
      cmp("model_BUS_ERR", int'(BUS_ERR), m_err);
    end
  end

  task automatic idle();
    SB_DATA = 8'h00; DAA_DATA = 8'h00;
    A_LOAD = 0; X_LOAD = 0; Y_LOAD = 0; S_LOAD = 0;
    AI_SB_LOAD = 0; AI_ZERO_LOAD = 0; S_INC = 0; S_DEC = 0;
    A_SB_EN = 0; X_SB_EN = 0; Y_SB_EN = 0; S_SB_EN = 0;
    A_DB_EN = 0; S_ADL_EN = 0; ERR_CLR = 0;
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic rand_inputs();
    int pick;
    A_LOAD = ($urandom_range(0, 3) == 0);
    X_LOAD = ($urandom_range(0, 3) == 0);
    Y_LOAD = ($urandom_range(0, 3) == 0);
    S_LOAD = ($urandom_range(0, 7) == 0);
    AI_SB_LOAD   = ($urandom_range(0, 3) == 0);
    AI_ZERO_LOAD = ($urandom_range(0, 3) == 0);
    S_INC = ($urandom_range(0, 2) == 0);
    S_DEC = ($urandom_range(0, 2) == 0);
    A_SB_EN = ($urandom_range(0, 3) == 0);
    X_SB_EN = ($urandom_range(0, 3) == 0);
    Y_SB_EN = ($urandom_range(0, 3) == 0);
    S_SB_EN = ($urandom_range(0, 3) == 0);
    A_DB_EN  = $urandom_range(0, 1) == 1;
    S_ADL_EN = $urandom_range(0, 1) == 1;
    ERR_CLR  = $urandom_range(0, 1) == 1;
    DAA_DATA = 8'($urandom);
    pick = int'($urandom_range(0, 3));
    case (pick)
      0: SB_DATA = 8'h00;
      1: SB_DATA = 8'hFF;
      default: SB_DATA = 8'($urandom);
    endcase
  endtask

  initial begin
    idle();
    #1 RST_N = 1'b0;
    #1 chk_en = 1'b1;
    #20 RST_N = 1'b1;

    // reset values
    S_ADL_EN = 1; #1;
    cmp("rst_ADL", int'(ADL_OUT), 8'hFF);
    cmp("rst_SB_idle", int'(SB_OUT), 8'hFF);
    cmp("rst_DB_idle", int'(DB_OUT), 8'hFF);
    cmp("rst_AI", int'(AI_OUT), 8'h00);
    cmp("rst_WRAP", int'(S_WRAP), 0);
    cmp("rst_ERR", int'(BUS_ERR), 0);
    A_DB_EN = 1; X_SB_EN = 1; #1;
    cmp("rst_A", int'(DB_OUT), 8'h00);
    cmp("rst_X", int'(SB_OUT), 8'h00);
    idle(); S_ADL_EN = 1;

    // S wrap up and down
    step(); S_INC = 1;
    step(); S_INC = 0;
    cmp("inc_S", int'(ADL_OUT), 8'h00);
    cmp("inc_WRAP", int'(S_WRAP), 1);
    step();
    cmp("inc_WRAP_1cyc", int'(S_WRAP), 0);
    S_DEC = 1;
    step(); S_DEC = 0;
    cmp("dec_S", int'(ADL_OUT), 8'hFF);
    cmp("dec_WRAP", int'(S_WRAP), 1);
    step();
    cmp("dec_WRAP_1cyc", int'(S_WRAP), 0);

    // S_LOAD beats DEC; INC+DEC holds
    S_LOAD = 1; S_DEC = 1; SB_DATA = 8'h10;
    step(); S_LOAD = 0;
    cmp("load_S", int'(ADL_OUT), 8'h10);
    cmp("load_WRAP", int'(S_WRAP), 0);
    S_INC = 1; S_DEC = 1;
    step(); S_INC = 0; S_DEC = 0;
    cmp("incdec_S", int'(ADL_OUT), 8'h10);
    cmp("incdec_WRAP", int'(S_WRAP), 0);

    // SB wired-AND and sticky error
    X_LOAD = 1; SB_DATA = 8'hF0;
    step(); X_LOAD = 0; Y_LOAD = 1; SB_DATA = 8'h3C;
    step(); Y_LOAD = 0;
    X_SB_EN = 1; Y_SB_EN = 1; #1;
    cmp("and_SB", int'(SB_OUT), 8'h30);
    cmp("and_CONFLICT", int'(BUS_CONFLICT), 1);
    cmp("and_ERR_pre", int'(BUS_ERR), 0);
    step(); X_SB_EN = 0; Y_SB_EN = 0; #1;
    cmp("err_set", int'(BUS_ERR), 1);
    cmp("err_no_conflict", int'(BUS_CONFLICT), 0);
    step();
    cmp("err_sticky", int'(BUS_ERR), 1);
    X_SB_EN = 1; S_SB_EN = 1; ERR_CLR = 1;
    step(); X_SB_EN = 0; S_SB_EN = 0;
    cmp("err_set_beats_clr", int'(BUS_ERR), 1);
    step(); ERR_CLR = 0;
    cmp("err_cleared", int'(BUS_ERR), 0);

    // AI priority
    AI_SB_LOAD = 1; AI_ZERO_LOAD = 1; SB_DATA = 8'h5A;
    step(); AI_SB_LOAD = 0;
    cmp("ai_sb_prio", int'(AI_OUT), 8'h5A);
    step(); AI_ZERO_LOAD = 0;
    cmp("ai_zero", int'(AI_OUT), 8'h00);
    step();
    cmp("ai_hold", int'(AI_OUT), 8'h00);

    // asynchronous reset mid-cycle
    A_LOAD = 1; DAA_DATA = 8'h99; A_DB_EN = 1;
    step(); A_LOAD = 0;
    cmp("a_load", int'(DB_OUT), 8'h99);
    #1 RST_N = 1'b0;
    #1;
    cmp("async_A", int'(DB_OUT), 8'h00);
    cmp("async_S", int'(ADL_OUT), 8'hFF);
    @(negedge CLK); #1 RST_N = 1'b1;
    idle();

    // randomized traffic, checked every cycle by the compare process
    for (int i = 0; i < 3000; i++) begin
      step();
      rand_inputs();
    end
    step();
    idle();
    step();
    chk_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
